// File: rtl/bus_deserializer.sv
// bus_deserializer: packs BUSWIDTH-bit beats into words of 2**SELWIDTH lanes, lane 0 in the LSBs.
// Optional BUS_DESERIALIZER_SKID_EN: accept the next word's first beat on the output transfer cycle.

module bus_deserializer_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // a write on the transfer cycle wins over the clear so a skid beat survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (we)  q <= d;
    else if (clr) q <= '0;
  end
endmodule

module bus_deserializer #(
  parameter int BUSWIDTH = 32,
  parameter int SELWIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [BUSWIDTH-1:0]               in_data,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [BUSWIDTH*(2**SELWIDTH)-1:0] out_data,
  output logic [SELWIDTH:0]                 out_len
);
  localparam int N = 2**SELWIDTH;
`ifdef BUS_DESERIALIZER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam logic [SELWIDTH-1:0] CNT_ONE  = 1;
  localparam logic [SELWIDTH-1:0] CNT_LAST = '1;
  localparam logic [SELWIDTH:0]   LEN_ONE  = 1;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                     state;
  logic [SELWIDTH-1:0]        cnt;
  logic                       acc;
  logic                       xfer;
  logic [N-1:0][BUSWIDTH-1:0] lanes;

  assign in_ready  = (state == FILL) || (SKID && out_ready);
  assign acc       = in_valid && in_ready;
  assign xfer      = (state == HOLD) && out_ready;
  assign out_valid = (state == HOLD);
  assign out_data  = lanes;

  // cnt is 0 throughout HOLD, so a skid beat lands in lane 0
  for (genvar i = 0; i < N; i++) begin : g_lane
    bus_deserializer_lane #(.W(BUSWIDTH)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (acc && (cnt == SELWIDTH'(i))),
      .clr  (xfer),
      .d    (in_data),
      .q    (lanes[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      cnt     <= '0;
      out_len <= '0;
    end else if (state == FILL) begin
      if (acc) begin
        if (cnt == CNT_LAST || flush) begin
          state   <= HOLD;
          out_len <= {1'b0, cnt} + LEN_ONE;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else if (flush && cnt != '0) begin
        state   <= HOLD;
        out_len <= {1'b0, cnt};
        cnt     <= '0;
      end
    end else if (out_ready) begin
      state   <= FILL;
      out_len <= '0;
      cnt     <= acc ? CNT_ONE : '0;
    end
  end
endmodule

// File: tb/tb_bus_deserializer.sv
// Randomised and directed bench for bus_deserializer against a queue-based word model.
module tb_bus_deserializer;
  localparam int BW = 8;
  localparam int SW = 2;
  localparam int N  = 4;
`ifdef BUS_DESERIALIZER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [BW-1:0]   in_data = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [BW*N-1:0] out_data;
  logic [SW:0]     out_len;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: beats collected for the open word, plus the word on offer
  bit              m_hold;
  bit              m_acc;
  logic [BW*N-1:0] m_word;
  logic [SW:0]     m_len;
  logic [BW-1:0]   m_beats[$];
  int              xfer_cyc[$];
  logic            seen_rdy;
  logic            exp_rdy;

  bus_deserializer #(.BUSWIDTH(BW), .SELWIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_len(out_len)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_hold = 1'b0;
    m_acc  = 1'b0;
    m_word = '0;
    m_len  = '0;
    m_beats.delete();
  endtask

  // one clock: drive just after a falling edge, update the model at the rising edge
  task automatic tick(input logic v, input logic [BW-1:0] d, input logic f, input logic r);
    bit was_hold;
    in_valid = v; in_data = d; flush = f; out_ready = r;
    #1;
    exp_rdy  = !m_hold || (SKID && r);
    seen_rdy = in_ready;
    m_acc    = v && exp_rdy;
    @(posedge clk);
    cyc++;
    was_hold = m_hold;
    if (m_hold && r) begin
      m_hold = 1'b0;
      xfer_cyc.push_back(cyc);
    end
    if (m_acc) m_beats.push_back(d);
    if (!was_hold && (m_beats.size() == N || (f && m_beats.size() > 0))) begin
      m_word = '0;
      foreach (m_beats[k]) m_word[BW*k +: BW] = m_beats[k];
      m_len  = (SW+1)'(m_beats.size());
      m_hold = 1'b1;
      m_beats.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (out_len !== '0) begin failures++; $display("FAIL reset_out_len got=%0d exp=0", out_len); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_word();
    tick(1, 8'h11, 0, 1); tick(1, 8'h22, 0, 1); tick(1, 8'h33, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%b exp=0", out_valid); end
    tick(1, 8'h44, 0, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h44332211) begin failures++; $display("FAIL full_data got=%h exp=44332211", out_data); end
    checks++; if (out_len !== 3'd4) begin failures++; $display("FAIL full_len got=%0d exp=4", out_len); end
    tick(0, 8'h00, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_after_xfer got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_back_fill got=%b exp=1", in_ready); end
  endtask

  task automatic test_partial_flush();
    tick(1, 8'hAA, 0, 1); tick(1, 8'hBB, 0, 1); tick(0, 8'h00, 1, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pflush_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h0000BBAA) begin failures++; $display("FAIL pflush_data got=%h exp=0000bbaa", out_data); end
    checks++; if (out_len !== 3'd2) begin failures++; $display("FAIL pflush_len got=%0d exp=2", out_len); end
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 1, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_flush_valid got=%b exp=0", out_valid); end
    tick(0, 8'h00, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_flush_late got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush_beat();
    tick(1, 8'h01, 0, 1); tick(1, 8'h02, 1, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fbeat_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 32'h00000201) begin failures++; $display("FAIL fbeat_data got=%h exp=00000201", out_data); end
    checks++; if (out_len !== 3'd2) begin failures++; $display("FAIL fbeat_len got=%0d exp=2", out_len); end
    tick(0, 8'h00, 0, 1);
    tick(1, 8'h05, 0, 1); tick(1, 8'h06, 0, 1); tick(1, 8'h07, 0, 1); tick(1, 8'h08, 1, 1);
    checks++; if (out_len !== 3'd4) begin failures++; $display("FAIL fbeat_full_len got=%0d exp=4", out_len); end
    checks++; if (out_data !== 32'h08070605) begin failures++; $display("FAIL fbeat_full_data got=%h exp=08070605", out_data); end
    tick(0, 8'h00, 0, 1);
  endtask

  task automatic test_backpressure();
    tick(1, 8'hDE, 0, 0); tick(1, 8'hAD, 0, 0); tick(1, 8'hBE, 0, 0); tick(1, 8'hEF, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick(1, 8'(k + 8'h50), 0, 0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, out_valid); end
      checks++; if (out_data !== 32'hEFBEADDE) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=efbeadde", k, out_data); end
      checks++; if (seen_rdy !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", k, seen_rdy); end
    end
    tick(0, 8'h00, 0, 1);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", out_valid); end
  endtask

  task automatic test_throughput();
    logic [BW-1:0] beats[12];
    int idx = 0;
    foreach (beats[k]) beats[k] = 8'($urandom);
    xfer_cyc.delete();
    for (int k = 0; k < 40 && (idx < 12 || xfer_cyc.size() < 3); k++) begin
      tick(idx < 12, idx < 12 ? beats[idx] : 8'h00, 0, 1);
      if (m_acc) idx++;
      checks++; if (seen_rdy !== exp_rdy) begin failures++; $display("FAIL tp_in_ready got=%b exp=%b", seen_rdy, exp_rdy); end
      checks++; if (out_valid !== m_hold) begin failures++; $display("FAIL tp_valid got=%b exp=%b", out_valid, m_hold); end
      if (m_hold) begin
        checks++; if (out_data !== m_word) begin failures++; $display("FAIL tp_data got=%h exp=%h", out_data, m_word); end
      end
    end
    checks++; if (xfer_cyc.size() != 3) begin failures++; $display("FAIL tp_words got=%0d exp=3", xfer_cyc.size()); end
    for (int k = 1; k < xfer_cyc.size(); k++) begin
      checks++;
      if (xfer_cyc[k] - xfer_cyc[k-1] != (SKID ? 4 : 5)) begin
        failures++; $display("FAIL tp_spacing got=%0d exp=%0d", xfer_cyc[k] - xfer_cyc[k-1], SKID ? 4 : 5);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 8'h9A, 0, 1); tick(1, 8'h9B, 0, 1);
    in_valid = 1'b1; in_data = 8'h77;
    #2; rst_n = 1'b0; #1;
    model_clear();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rmid_data got=%h exp=0", out_data); end
    @(negedge clk); rst_n = 1'b1;
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rmid_no_capture got=%h exp=0", out_data); end
    tick(1, 8'hC1, 0, 1); tick(1, 8'hC2, 0, 1); tick(1, 8'hC3, 0, 1); tick(1, 8'hC4, 0, 0);
    checks++; if (out_data !== 32'hC4C3C2C1) begin failures++; $display("FAIL rmid_fresh got=%h exp=c4c3c2c1", out_data); end
    #2; rst_n = 1'b0; #1;
    model_clear();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rhold_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rhold_data got=%h exp=0", out_data); end
    checks++; if (out_len !== '0) begin failures++; $display("FAIL rhold_len got=%0d exp=0", out_len); end
    @(negedge clk); rst_n = 1'b1;
    tick(1, 8'hD1, 0, 1); tick(1, 8'hD2, 0, 1); tick(1, 8'hD3, 0, 1); tick(1, 8'hD4, 0, 1);
    checks++; if (out_data !== 32'hD4D3D2D1) begin failures++; $display("FAIL rhold_fresh got=%h exp=d4d3d2d1", out_data); end
    tick(0, 8'h00, 0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
      checks++; if (seen_rdy !== exp_rdy) begin failures++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", k, seen_rdy, exp_rdy); end
      checks++; if (out_valid !== m_hold) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", k, out_valid, m_hold); end
      if (m_hold) begin
        checks++; if (out_data !== m_word) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", k, out_data, m_word); end
        checks++; if (out_len !== m_len) begin failures++; $display("FAIL rnd_len[%0d] got=%0d exp=%0d", k, out_len, m_len); end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_full_word();
    test_partial_flush();
    test_flush_beat();
    test_backpressure();
    test_throughput();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_deserializer.md
# bus_deserializer

Sequential counterpart of the lane mux: collects a stream of narrow `BUSWIDTH`-bit beats into one wide word of `2**SELWIDTH` lanes. It uses valid/ready handshakes on both sides and has a flush for partial words. It sits between narrow producers (fetch/load byte-lane paths, debug serial links) and wide consumers. Lane `i` of the output uses the same packing as the codebase's multiplexer library, `[BUSWIDTH*i +: BUSWIDTH]`, with lane 0 (the first beat) in the LSBs.

## Interface
Parameters:
- `BUSWIDTH`, default 32: width of one beat / lane.
- `SELWIDTH`, default 2: lane-index width; number of lanes `N = 2**SELWIDTH`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset; asynchronous, active-low.
- `in_valid` input 1: beat present.
- `in_ready` output 1: block accepts the beat this cycle.
- `in_data` input `BUSWIDTH`: beat payload.
- `flush` input 1: close the current partial word.
- `out_valid` output 1: wide word present.
- `out_ready` input 1: consumer takes the word this cycle.
- `out_data` output `BUSWIDTH*N`: packed word; lane `i` = `[BUSWIDTH*i +: BUSWIDTH]`.
- `out_len` output `SELWIDTH+1`: number of valid lanes, 1..N.

## Operation
- Handshakes:
  - Input beat accepted when `in_valid & in_ready` at a clock edge.
  - Output word transferred when `out_valid & out_ready`.
- State:
  - Lane counter `cnt` (SELWIDTH bits).
  - Data register `N*BUSWIDTH` bits.
  - FSM with states FILL and HOLD.
- FILL:
  - `in_ready=1`, `out_valid=0`.
  - An accepted beat writes lane `cnt` and increments `cnt`.
  - The beat that fills lane N-1 moves the FSM to HOLD with `out_len=N`; `cnt` wraps to 0.
- Flush in FILL:
  - `flush` with `cnt>0` and no accepted beat → HOLD, `out_len=cnt`, `cnt` cleared.
  - `flush` together with an accepted beat: the beat is written first, then the word closes with `out_len=cnt+1`.
  - If that beat also fills lane N-1, `out_len=N` (same as a normal fill).
  - `flush` with `cnt==0` and no beat is ignored.
- HOLD:
  - `out_valid=1`; `out_data` and `out_len` are stable until the output transfer.
  - `flush` is ignored.
  - Beat acceptance in HOLD is governed by the Configuration macro.
- Output transfer: returns the FSM to FILL and zeroes the data register (except a lane written in the same cycle, see Configuration).
- Lanes never written in a partial word read as 0.
- Arithmetic: `cnt` wraps modulo N, so no overflow is possible. `out_len` is the only value that can equal N and therefore needs `SELWIDTH+1` bits.

## Timing
- Reset (`rst_n` low, asynchronous, takes effect immediately):
  - State FILL, `cnt=0`, data register 0.
  - `out_valid=0`, `out_len=0`, `out_data=0`.
  - `in_ready=1` combinationally, but no beat is captured while `rst_n` is low.
- Reset mid-word or in HOLD discards the partial or held word; there is no output transfer.
- Latency: `out_valid` rises on the cycle after the edge that accepts the last beat (registered). No combinational path runs from `in_data` to `out_data`.
- `in_ready` is combinational from state and (macro on) `out_ready`. `out_valid`, `out_data` and `out_len` are registered.
- Throughput:
  - Macro off: one word per N+1 cycles.
  - Macro on: one word per N cycles.
- A consumer holding `out_ready=0` stalls the block indefinitely without loss.

## Configuration
Macro `BUS_DESERIALIZER_SKID_EN`:
- Defined:
  - In HOLD, `in_ready = out_ready`.
  - A beat accepted on the output-transfer cycle is written into lane 0 of the freshly cleared register, and `cnt` becomes 1.
  - Back-to-back words run with no bubble.
- Undefined:
  - In HOLD, `in_ready=0`.
  - The first beat of the next word is accepted at the earliest one cycle after the output transfer.

## Test plan
Default configuration for all tests: `BUSWIDTH=8`, `SELWIDTH=2` (N=4).
1. Full word: beats 0x11,0x22,0x33,0x44 on consecutive cycles with `out_ready=1` → `out_valid` one cycle later, `out_data=0x44332211`, `out_len=4`, then back in FILL.
2. Partial flush: beats 0xAA,0xBB, then `flush` alone → `out_data=0x0000BBAA`, `out_len=2`. A later `flush` with `cnt==0` produces no output.
3. Flush with beat: 0x01, then 0x02 with `flush` in the same cycle → `out_len=2`, `out_data=0x00000201`. Also 3 beats then a 4th beat with `flush` → `out_len=4`.
4. Backpressure: full word with `out_ready=0` for 5 cycles → `out_valid` and `out_data` held constant and `in_ready=0` throughout; transfer completes on the cycle `out_ready` rises.
5. Throughput: continuous `in_valid` over 3 words, `out_ready=1` → output transfers spaced 5 cycles apart (macro off) or 4 cycles apart (macro on), all data intact.
6. Reset: assert `rst_n` low after 2 beats, and separately while in HOLD → immediately `out_valid=0` and `out_data=0`. After release, a new 4-beat word appears with no stale lanes.
